// File: rtl/mp_result_writer.sv
// rtl/mp_result_writer.sv - buffers 4-lane result vectors and serializes them into word writes
//
// Purpose: accepts result vectors from the matrix processor write strobe into a
// small FIFO, then emits one memory word per handshake on a valid/ready write
// port with sequential addresses starting at a per-job base. A one-cycle done
// pulse marks the handshake of the last word of the programmed vector count.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   job_start                    pulse; latches job_base_addr/job_count in IDLE
//   job_base_addr, job_count     first word address, number of vectors
//   res_valid, res_data          incoming vector (lane0 in the low bits)
//   res_ready                    FIFO not full
//   mem_wvalid/waddr/wdata       write request toward the arbiter
//   mem_wready                   arbiter accepts the write
//   busy, done, overflow         status: not idle, completion pulse, sticky drop flag
module mp_result_writer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 8,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                job_start,
    input  logic [ADDR_W-1:0]   job_base_addr,
    input  logic [CNT_W-1:0]    job_count,
    input  logic                res_valid,
    input  logic [4*DATA_W-1:0] res_data,
    output logic                res_ready,
    output logic                mem_wvalid,
    output logic [ADDR_W-1:0]   mem_waddr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_wready,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [4*DATA_W-1:0] fifo_q [DEPTH];
    logic [PW:0]         wptr_q, wptr_d;
    logic [PW:0]         rptr_q, rptr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
    logic [1:0]          idx_q, idx_d;
    logic                ovf_q, ovf_d;

    logic                full;
    logic                empty;
    logic                run;
    logic                push;
    logic                hs;
    logic [4*DATA_W-1:0] head;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign empty = (wptr_q == rptr_q);
    assign run   = (state_q == S_RUN);

    // Space is judged on registered occupancy only; a same-cycle pop does not help.
    assign push = run && res_valid && !full && (acc_cnt_q != '0);
    assign hs   = mem_wvalid && mem_wready;
    assign head = fifo_q[rptr_q[PW-1:0]];

    assign res_ready  = !full;
    assign mem_wvalid = run && !empty;
    assign mem_waddr  = addr_q;
    // Gated so the unreset storage never leaks onto the bus while idle.
    assign mem_wdata  = mem_wvalid ? head[idx_q*DATA_W +: DATA_W] : '0;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign overflow   = ovf_q;

    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        addr_d    = addr_q;
        acc_cnt_d = acc_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        idx_d     = idx_q;
        ovf_d     = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (job_start) begin
                    addr_d    = job_base_addr;
                    acc_cnt_d = job_count;
                    wr_cnt_d  = job_count;
                    idx_d     = 2'd0;
                    ovf_d     = 1'b0;
                    state_d   = (job_count == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (push) begin
                    wptr_d    = wptr_q + (PW+1)'(1);
                    acc_cnt_d = acc_cnt_q - CNT_W'(1);
                end
                // Only vectors the job still wants count as lost.
                if (res_valid && full && (acc_cnt_q != '0)) begin
                    ovf_d = 1'b1;
                end
                if (hs) begin
                    addr_d = addr_q + ADDR_W'(1);
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        rptr_d   = rptr_q + (PW+1)'(1);
                        wr_cnt_d = wr_cnt_q - CNT_W'(1);
                        if (wr_cnt_q == CNT_W'(1)) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            addr_q    <= '0;
            acc_cnt_q <= '0;
            wr_cnt_q  <= '0;
            idx_q     <= 2'd0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            addr_q    <= addr_d;
            acc_cnt_q <= acc_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            idx_q     <= idx_d;
            ovf_q     <= ovf_d;
        end
    end

    // Vector storage needs no reset: occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wptr_q[PW-1:0]] <= res_data;
        end
    end

endmodule
